// File: rtl/syscall_io_unit_pkg.sv
// Shared definitions for the SYSCALL I/O unit: syscall codes and FSM state encodings.
package syscall_io_unit_pkg;

    // Syscall codes as presented on ACC; compared against the full machine word.
    localparam int unsigned SYS_HALT  = 0;
    localparam int unsigned SYS_READ  = 1;
    localparam int unsigned SYS_WRITE = 2;

    // Unit states. IO_HALT is terminal and only left through reset.
    typedef enum logic [2:0] {
        IO_IDLE = 3'd0,
        IO_TX   = 3'd1,
        IO_RX   = 3'd2,
        IO_NOP  = 3'd3,
        IO_HALT = 3'd4
    } io_state_e;

endpackage : syscall_io_unit_pkg

// File: rtl/syscall_io_unit.sv
// SYSCALL executor: takes a code/operand from the controller and moves whole
// machine words over byte-wide RX/TX valid/ready streams, MSB byte first.
//
// Handshakes: a byte moves on a rising clock edge where the producer's valid and
// the consumer's ready are both 1. On TX the unit holds tx_data stable while
// tx_valid is high and tx_ready is low. On RX the unit raises rx_ready only in
// the RX state, so bytes offered at any other time are left with the PHY.
module syscall_io_unit
    import syscall_io_unit_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             runio,
    input  logic [WIDTH-1:0] code,
    input  logic [WIDTH-1:0] arg,
    output logic             iobusy,
    output logic [WIDTH-1:0] iodata,
    output logic             halted,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    input  logic [7:0]       rx_data,
    output logic             rx_ready,
    input  logic             rx_valid
);

    localparam int BYTES = WIDTH / 8;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES - 1);

    io_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] iodata_q, iodata_d;
    logic [WIDTH-1:0] rx_shift;

    // Received byte enters at the bottom; the oldest byte falls off the top.
    assign rx_shift = WIDTH'({sh_q, rx_data});

    // State and datapath registers; reset aborts any transfer in progress.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IO_IDLE;
            cnt_q    <= '0;
            sh_q     <= '0;
            iodata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            iodata_q <= iodata_d;
        end
    end

    // Next-state, datapath update and stream outputs, decoded from registered state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        iodata_d = iodata_q;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        rx_ready = 1'b0;
        case (state_q)
            IO_IDLE: begin
                if (runio) begin
                    sh_d  = arg;
                    cnt_d = '0;
                    if (code == WIDTH'(SYS_HALT))       state_d = IO_HALT;
                    else if (code == WIDTH'(SYS_READ))  state_d = IO_RX;
                    else if (code == WIDTH'(SYS_WRITE)) state_d = IO_TX;
                    else                                state_d = IO_NOP;
                end
            end
            IO_TX: begin
                tx_valid = 1'b1;
                tx_data  = sh_q[WIDTH-1 -: 8];
                if (tx_ready) begin
                    sh_d  = sh_q << 8;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) state_d = IO_IDLE;
                end
            end
            IO_RX: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    sh_d  = rx_shift;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        iodata_d = rx_shift;
                        state_d  = IO_IDLE;
                    end
                end
            end
            IO_NOP: begin
                state_d = IO_IDLE;
            end
            IO_HALT: begin
                state_d = IO_HALT;
            end
            default: begin
                state_d = IO_IDLE;
            end
        endcase
    end

    assign iobusy = (state_q != IO_IDLE);
    assign halted = (state_q == IO_HALT);
    assign iodata = iodata_q;

endmodule : syscall_io_unit

// File: tb/tb_syscall_io_unit.sv
// Directed bench for syscall_io_unit: a table of single transactions plus
// hand-written stall, gap, reset-abort and halt sequences.
module tb_syscall_io_unit;

    logic        clock;
    logic        reset;
    logic        runio;
    logic [15:0] code;
    logic [15:0] arg;
    logic        iobusy;
    logic [15:0] iodata;
    logic        halted;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        rx_valid;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [15:0] code;
        logic [15:0] arg;
        logic [15:0] rx_word;
        logic [15:0] exp_tx_word;
        logic [15:0] exp_iodata;
        int          exp_busy;
        int          exp_ntx;
        int          exp_nrx;
    } vec_t;

    vec_t vecs[8];

    syscall_io_unit #(.WIDTH(16)) dut (
        .clock    (clock),
        .reset    (reset),
        .runio    (runio),
        .code     (code),
        .arg      (arg),
        .iobusy   (iobusy),
        .iodata   (iodata),
        .halted   (halted),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .rx_valid (rx_valid)
    );

    // Clock and reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Start a syscall; returns at the negedge after the start edge.
    task automatic do_start(input logic [15:0] c, input logic [15:0] a);
        runio = 1'b1;
        code  = c;
        arg   = a;
        @(negedge clock);
        runio = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " iobusy"},   {31'd0, iobusy},   32'd0);
        check({tag, " halted"},   {31'd0, halted},   32'd0);
        check({tag, " tx_valid"}, {31'd0, tx_valid}, 32'd0);
        check({tag, " rx_ready"}, {31'd0, rx_ready}, 32'd0);
        check({tag, " tx_data"},  {24'd0, tx_data},  32'd0);
        check({tag, " iodata"},   {16'd0, iodata},   32'd0);
    endtask

    // One transaction with the PHY always ready/valid; counts busy cycles and handshakes.
    task automatic run_txn(input string tag, input vec_t v);
        int busy = 0;
        int ntx = 0;
        int nrx = 0;
        int both = 0;
        logic [15:0] txw = '0;
        do_start(v.code, v.arg);
        tx_ready = 1'b1;
        rx_valid = 1'b1;
        while (iobusy && busy < 20) begin
            rx_data = (nrx == 0) ? v.rx_word[15:8] : v.rx_word[7:0];
            if (tx_valid && rx_ready) both++;
            if (tx_valid) begin
                txw = {txw[7:0], tx_data};
                ntx++;
            end
            if (rx_ready) nrx++;
            busy++;
            @(negedge clock);
        end
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        check({tag, " busy_cycles"}, busy, v.exp_busy);
        check({tag, " tx_count"},    ntx,  v.exp_ntx);
        check({tag, " rx_count"},    nrx,  v.exp_nrx);
        if (v.exp_ntx == 2) check({tag, " tx_word"}, {16'd0, txw}, {16'd0, v.exp_tx_word});
        check({tag, " iodata"},      {16'd0, iodata}, {16'd0, v.exp_iodata});
        check({tag, " tx_rx_both"},  both, 0);
        check({tag, " rx_ready_after"}, {31'd0, rx_ready}, 32'd0);
    endtask

    initial begin
        int bad;
        // code, arg, rx_word, exp_tx_word, exp_iodata, busy, ntx, nrx
        vecs[0] = '{16'h0002, 16'hA55A, 16'h0000, 16'hA55A, 16'h0000, 2, 2, 0};
        vecs[1] = '{16'h0001, 16'hFFFF, 16'h1234, 16'h0000, 16'h1234, 2, 0, 2};
        vecs[2] = '{16'h0007, 16'hFFFF, 16'h0000, 16'h0000, 16'h1234, 1, 0, 0};
        vecs[3] = '{16'h0002, 16'h00FF, 16'h0000, 16'h00FF, 16'h1234, 2, 2, 0};
        vecs[4] = '{16'h0001, 16'h0000, 16'hBEEF, 16'h0000, 16'hBEEF, 2, 0, 2};
        vecs[5] = '{16'h0102, 16'h5555, 16'h0000, 16'h0000, 16'hBEEF, 1, 0, 0};
        vecs[6] = '{16'h0100, 16'h5555, 16'h0000, 16'h0000, 16'hBEEF, 1, 0, 0};
        vecs[7] = '{16'h0001, 16'h0000, 16'hA005, 16'h0000, 16'hA005, 2, 0, 2};

        reset = 1'b0; runio = 1'b0; code = '0; arg = '0;
        tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b1;
        @(negedge clock);
        check_all_zero("post_reset_idle");

        // Table: each transaction starts in the first idle cycle of the previous one.
        for (int i = 0; i < 8; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

        // WRITE stalled 5 cycles on the first byte.
        do_start(16'h0002, 16'hA55A);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (!(tx_valid === 1'b1 && tx_data === 8'hA5 && iobusy === 1'b1)) bad++;
            @(negedge clock);
        end
        check("stall hold", bad, 0);
        tx_ready = 1'b1;
        check("stall byte0", {24'd0, tx_data}, 32'hA5);
        @(negedge clock);
        check("stall byte1", {24'd0, tx_data}, 32'h5A);
        check("stall busy1", {31'd0, iobusy}, 32'd1);
        @(negedge clock);
        tx_ready = 1'b0;
        check("stall done", {31'd0, iobusy}, 32'd0);
        check("stall iodata", {16'd0, iodata}, 32'hA005);

        // READ with a 3-cycle gap between bytes.
        do_start(16'h0001, 16'h0000);
        rx_valid = 1'b1; rx_data = 8'h12;
        @(negedge clock);
        rx_valid = 1'b0; rx_data = 8'hEE;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (!(iobusy === 1'b1 && rx_ready === 1'b1)) bad++;
            @(negedge clock);
        end
        check("gap hold", bad, 0);
        rx_valid = 1'b1; rx_data = 8'h34;
        @(negedge clock);
        rx_valid = 1'b0;
        check("gap busy_fall", {31'd0, iobusy}, 32'd0);
        check("gap iodata", {16'd0, iodata}, 32'h1234);
        check("gap rx_ready", {31'd0, rx_ready}, 32'd0);
        // Stray rx_valid while idle must not be consumed.
        rx_valid = 1'b1; rx_data = 8'h99;
        @(negedge clock);
        check("idle rx_ready", {31'd0, rx_ready}, 32'd0);
        rx_valid = 1'b0;

        // Reset in the middle of a WRITE after the first byte.
        do_start(16'h0002, 16'hA55A);
        tx_ready = 1'b1;
        @(negedge clock);
        tx_ready = 1'b0;
        check("abort second_byte", {24'd0, tx_data}, 32'h5A);
        reset = 1'b0;
        #1;
        check_all_zero("abort");
        @(negedge clock);
        reset = 1'b1;
        run_txn("rewrite", '{16'h0002, 16'hA55A, 16'h0000, 16'hA55A, 16'h0000, 2, 2, 0});

        // HALT is terminal regardless of inputs.
        do_start(16'h0000, 16'h0000);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            runio    = 1'($urandom_range(0, 1));
            tx_ready = 1'($urandom_range(0, 1));
            rx_valid = 1'($urandom_range(0, 1));
            code     = 16'($urandom_range(0, 3));
            if (!(halted === 1'b1 && iobusy === 1'b1 && tx_valid === 1'b0 && rx_ready === 1'b0)) bad++;
            @(negedge clock);
        end
        check("halt persist", bad, 0);
        runio = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("halt reset halted", {31'd0, halted}, 32'd0);
        check("halt reset iobusy", {31'd0, iobusy}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_syscall_io_unit
